uart_frame_bit_counter: RTL

//  Parametrised bit-time counter for the UART TX and RX engines. Counts bit-time-up (btu)

---
 rtl/uart_frame_bit_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_frame_bit_counter.sv
// Bit-time counter for one UART frame: bit index, last-bit flag and a done pulse.
// Optional completed-frame counter when UART_FRAME_CNT_EN is defined.
module uart_frame_bit_counter #(
  parameter int CNT_W       = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btu,
  input  logic                   doit,
  input  logic [1:0]             data_bits,
  input  logic                   parity_en,
  input  logic                   two_stop,
  output logic [CNT_W-1:0]       bit_idx,
  output logic [CNT_W-1:0]       frame_len,
  output logic                   last_bit,
  output logic                   busy,
  output logic                   done
`ifdef UART_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  // state    | meaning
  // ST_IDLE  | no frame, bit_idx held at 0, waiting for doit
  // ST_COUNT | frame running, counting btu ticks
  // ST_DONE  | frame complete, bit_idx parked at frame_len until doit drops
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cfg_len;

  if (CNT_W < 4) begin : g_cnt_w_chk
    $error("CNT_W must be at least 4 to hold a 12-bit frame");
  end
  if (FRAME_CNT_W < 1) begin : g_frame_cnt_w_chk
    $error("FRAME_CNT_W must be at least 1");
  end

  // start + data + optional parity + stop bits, range 7..12
  assign cfg_len = CNT_W'(7) + CNT_W'(data_bits) + CNT_W'(parity_en) + CNT_W'(two_stop);

  assign last_bit = (state == ST_COUNT) && (bit_idx == frame_len - CNT_W'(1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      frame_len   <= '0;
      done        <= 1'b0;
`ifdef UART_FRAME_CNT_EN
      frame_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          if (doit) begin
            frame_len <= cfg_len;
            state     <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // abort takes priority over a coincident btu
          if (!doit) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
          end else if (btu) begin
            bit_idx <= bit_idx + CNT_W'(1);
            if (last_bit) begin
              done  <= 1'b1;
              state <= ST_DONE;
`ifdef UART_FRAME_CNT_EN
              frame_count <= frame_count + FRAME_CNT_W'(1);
`endif
            end
          end
        end
        ST_DONE: begin
          if (!doit) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule
